// File: rtl/serializer_pkg.sv
// Shared widths, state encoding and length decode for the 16-bit serializer.
package serializer_pkg;

    localparam int DATA_W = 16;
    localparam int MOD_W  = 4;
    localparam int CNT_W  = 5;

    localparam logic [CNT_W-1:0] MIN_LEN = 5'd3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // A mod of 0 stands for a full word, which needs one more bit than MOD_W holds.
    function automatic logic [CNT_W-1:0] eff_len(input logic [MOD_W-1:0] mod);
        return (mod == '0) ? 5'd16 : {1'b0, mod};
    endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial transmitter: latches a word on strobe, shifts it out MSB-first
// with a per-bit valid. All outputs come straight from flops.
module serializer
    import serializer_pkg::*;
(
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    ser_state_t        state, state_n;
    logic [DATA_W-1:0] shift_reg, shift_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CNT_W-1:0]  len;
    logic              accept;

    assign len    = eff_len(data_mod_i);
    assign accept = data_val_i && (state == IDLE) && (len >= MIN_LEN);

    // cnt holds the number of bits still to be shown, including the one on the output.
    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SEND;
                    shift_n = data_i;
                    cnt_n   = len;
                end
            end
            SEND: begin
                shift_n = {shift_reg[DATA_W-2:0], 1'b0};
                cnt_n   = cnt - 5'd1;
                if (cnt == 5'd1)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered copies of the next state, so they line up with it exactly.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state          <= IDLE;
            shift_reg      <= '0;
            cnt            <= '0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state          <= state_n;
            shift_reg      <= shift_n;
            cnt            <= cnt_n;
            ser_data_o     <= (state_n == SEND) && shift_n[DATA_W-1];
            ser_data_val_o <= (state_n == SEND);
            busy_o         <= (state_n == SEND);
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Directed and randomized checks of the serializer against hand-derived bit streams.
module tb_serializer;

    logic        clk_i = 1'b0;
    logic        srst_i;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        data_val_i;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    serializer dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic strobe(input logic [15:0] d, input logic [3:0] m);
        data_i     = d;
        data_mod_i = m;
        data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_val"},  {31'd0, ser_data_val_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o},         32'd0);
        chk({tag, "_data"}, {31'd0, ser_data_o},     32'd0);
    endtask

    // Called in cycle N+1; checks L bits, the idle gap, and the rebuilt word.
    task automatic expect_word(input string tag, input logic [15:0] d, input int len);
        logic [15:0] rebuilt;
        logic [15:0] want;
        rebuilt = '0;
        for (int i = 0; i < len; i++) begin
            chk({tag, "_bit"},  {31'd0, ser_data_o},     {31'd0, d[15-i]});
            chk({tag, "_val"},  {31'd0, ser_data_val_o}, 32'd1);
            chk({tag, "_busy"}, {31'd0, busy_o},         32'd1);
            rebuilt = {rebuilt[14:0], ser_data_o};
            tick();
        end
        chk_idle({tag, "_gap"});
        want = d >> (16 - len);
        chk({tag, "_word"}, {16'd0, rebuilt}, {16'd0, want});
    endtask

    initial begin
        int len;
        logic [3:0]  m;
        logic [15:0] d;

        srst_i     = 1'b1;
        data_i     = '0;
        data_mod_i = '0;
        data_val_i = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        srst_i = 1'b0;

        // Full word
        strobe(16'hA5C3, 4'd0);
        expect_word("full", 16'hA5C3, 16);

        // Partial word: 1,1,1,1,0
        strobe(16'hF000, 4'd5);
        expect_word("part", 16'hF000, 5);

        // Illegal lengths dropped, legal word right after accepted
        strobe(16'hFFFF, 4'd1);
        chk_idle("ill1");
        strobe(16'hFFFF, 4'd2);
        chk_idle("ill2");
        strobe(16'hB000, 4'd4);
        expect_word("after_ill", 16'hB000, 4);

        // Strobe while busy is ignored; a third word at N+17 goes through
        strobe(16'hFFFF, 4'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 4) begin
                data_i     = 16'h0000;
                data_mod_i = 4'd0;
                data_val_i = 1'b1;
            end else begin
                data_val_i = 1'b0;
            end
            chk("busy_ign_bit", {31'd0, ser_data_o},     32'd1);
            chk("busy_ign_val", {31'd0, ser_data_val_o}, 32'd1);
            tick();
        end
        chk_idle("busy_ign_end");
        strobe(16'h1234, 4'd0);
        expect_word("third", 16'h1234, 16);

        // Reset mid-transfer aborts; next word is complete
        strobe(16'hA5C3, 4'd0);
        for (int i = 0; i < 6; i++) begin
            chk("pre_rst_bit", {31'd0, ser_data_o}, {31'd0, 16'hA5C3 >> (15 - i)} & 32'd1);
            tick();
        end
        srst_i = 1'b1;
        tick();
        chk_idle("mid_rst");
        srst_i = 1'b0;
        strobe(16'h8E71, 4'd9);
        expect_word("post_rst", 16'h8E71, 9);

        // Reset and strobe together: reset wins
        srst_i     = 1'b1;
        strobe(16'hFFFF, 4'd0);
        srst_i     = 1'b0;
        chk_idle("rst_vs_strobe");
        tick();
        chk_idle("rst_vs_strobe2");

        // Randomized back-to-back
        for (int n = 0; n < 1000; n++) begin
            d = 16'($urandom);
            m = 4'($urandom_range(0, 13));
            if (m != 0) m = m + 4'd2;
            len = (m == 0) ? 16 : int'(m);
            chk("rnd_ready", {31'd0, busy_o}, 32'd0);
            strobe(d, m);
            expect_word("rnd", d, len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/serializer.md
# serializer

Parallel-to-serial transmitter, the counterpart of the 16-bit deserializer. It accepts a 16-bit word and a bit count on a single-cycle valid strobe. It then shifts the selected bits out MSB-first, one per clock, with a per-bit valid, so the deserializer on the far end rebuilds the word in the same bit order. A busy flag tells the upstream source when the next word may be offered.

## Interface
- Parameters: none. Widths come from `serializer_pkg` (DATA_W = 16, MOD_W = 4).
- `clk_i` input 1: single clock, all logic on rising edge.
- `srst_i` input 1: reset, synchronous, active-high.
- `data_i` input 16: parallel word to transmit.
- `data_mod_i` input 4: number of bits to send, counted from bit 15 downward. The value 0 means all 16 bits.
- `data_val_i` input 1: word strobe. `data_i` and `data_mod_i` are sampled only when this strobe is high and `busy_o` is low.
- `ser_data_o` output 1: serial data, MSB-first.
- `ser_data_val_o` output 1: `ser_data_o` holds a valid bit this cycle.
- `busy_o` output 1: a transfer is in progress and new words are ignored.

## Operation
- Effective length L = 16 when `data_mod_i` = 0, otherwise L = `data_mod_i`.
- L = 1 or L = 2 is illegal. Such a word is dropped:
  - no output activity;
  - `busy_o` stays low;
  - the block is ready again on the next cycle.
- Accept condition: `data_val_i` && !`busy_o` && L ≥ 3.
- On accept, the block latches the word into a 16-bit shift register and loads the bit counter with L.
- State machine, two states:
  - IDLE -> SEND on accept.
  - SEND -> IDLE in the cycle the last bit is on the output, with the counter going to 0.
- In SEND, each cycle:
  - `ser_data_o` = shift_reg[15];
  - `ser_data_val_o` = 1;
  - the register shifts left by 1, filling with 0;
  - the counter decrements by 1.
- Bits sent, in order: `data_i`[15], [14], … down to [16−L].
- `data_val_i` while `busy_o` = 1 is ignored. The current transfer is unaffected and the new word is not queued.
- `ser_data_o` is driven 0 whenever `ser_data_val_o` = 0.
- `srst_i` asserted mid-transfer aborts the transfer. The partial word is lost and nothing resumes after reset.

## Timing
- Reset values: `ser_data_o` = 0, `ser_data_val_o` = 0, `busy_o` = 0. The state is IDLE and the counter is 0.
- All outputs are registered.
- Accept at cycle N puts the first bit on `ser_data_o` with `ser_data_val_o` = 1 at cycle N+1.
- The last bit appears at cycle N+L.
- `busy_o` = 1 in exactly cycles N+1 … N+L, i.e. identical to `ser_data_val_o`.
- The earliest next accept is cycle N+L+1, so its first bit arrives at N+L+2.
- Back-to-back words therefore carry a one-cycle gap with `ser_data_val_o` = 0.
- `srst_i` high at cycle R: all outputs are 0 from cycle R+1. An accept is possible at the first cycle with `srst_i` low.
- `data_val_i` and `srst_i` high together: reset wins and the word is not accepted.

## Structure
- `serializer_pkg` holds:
  - DATA_W = 16 and MOD_W = 4;
  - MIN_LEN = 3;
  - the state enum `ser_state_t` {IDLE, SEND};
  - the function `eff_len(mod)` returning a 5-bit length (0 → 16).
- The counter is 5 bits wide, because 16 does not fit in MOD_W bits.
- No sub-module. A single `serializer` module holds the FSM, counter and shift register.

## Test plan
- Full word: `data_i` = 16'hA5C3, `data_mod_i` = 0, strobe at N.
  - Required: bits 1010_0101_1100_0011 on cycles N+1…N+16.
  - `ser_data_val_o` and `busy_o` high for exactly 16 cycles.
  - A looped-back deserializer outputs 16'hA5C3.
- Partial word: `data_i` = 16'hF000, `data_mod_i` = 5.
  - Required: bits 1,1,1,1,0 on cycles N+1…N+5, then `busy_o` = 0 at N+6.
- Illegal lengths: `data_mod_i` = 1, then `data_mod_i` = 2.
  - Required: `ser_data_val_o` and `busy_o` stay 0.
  - A legal word strobed the very next cycle is accepted.
- Strobe while busy: send 16'hFFFF (mod 0), then strobe 16'h0000 at N+5.
  - Required: 16 ones and no zero-word transfer.
  - A third strobe at N+17 is accepted, with its first bit at N+18.
- Reset mid-transfer: assert `srst_i` at N+7 of a 16-bit transfer.
  - Required: all outputs 0 at N+8.
  - A new word sent after reset is transmitted complete and correct.
- Randomized back-to-back: 1000 random words and mods (excluding 1 and 2), strobed whenever `busy_o` = 0.
  - Required: a scoreboard matches every bit and sees the 1-cycle inter-word gap.
